fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch (IF) stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID decode register.
- Owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO.
- Presents Instr/PC/PC_plus4 plus a valid flag to the decode register; honours stalls and branch/jump redirects from EX.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- BUF_DEPTH, 2, instruction buffer entries (power of 2, ≥2).
- MAX_OUTSTANDING, 2, maximum granted-but-unreturned imem requests.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en_n  in  1  active-low enable from hazard unit; 1 = decode stalled, hold buffer head
- redirect  in  1  EX redirect (taken branch/jump); also flushes IF
- redirect_pc  in  32  redirect target
- imem_req  out  1  request valid
- imem_addr  out  32  request address (word aligned)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid (in-order, ≥1 cycle after gnt)
- imem_rdata  in  32  response instruction
- Instr  out  32  buffer head instruction, or NOP 32'h0000_0013 when invalid
- PC  out  32  address of Instr
- PC_plus4  out  32  PC + 4
- instr_valid  out  1  buffer head valid
- misalign_err  out  1  see Optional Feature

Behaviour:
- Reset (async): fetch_pc=RESET_PC, buffer empty, outstanding=0, drop_cnt=0, state=RUN, imem_req=0, instr_valid=0, Instr=NOP, PC=0, PC_plus4=4, misalign_err=0.
- imem_req=1 when state==RUN && (buffered + outstanding) < BUF_DEPTH && outstanding < MAX_OUTSTANDING && !redirect.
- imem_addr=fetch_pc.
- On imem_req && imem_gnt: fetch_pc += 4 (32-bit wrap; 32'hFFFF_FFFC → 0), outstanding += 1.
- imem_rvalid in RUN: push {imem_rdata, addr} into buffer, outstanding -= 1. The address is tracked in a parallel addr FIFO written at grant time.
- Simultaneous gnt and rvalid: outstanding unchanged.
- Pop: instr_valid && !en_n pops the head at the clock edge; the next entry appears the following cycle.
- Push and pop in the same cycle on a full buffer is legal; count is unchanged.
- Zero-latency bypass is not required. First instr_valid is ≥2 cycles after first grant.
- Redirect (any state, highest priority):
  - fetch_pc ← redirect_pc, buffer cleared, drop_cnt ← outstanding (including any gnt this cycle), outstanding ← 0.
  - Responses in that cycle are discarded.
  - If drop_cnt ≠ 0, state ← DRAIN.
  - imem_req is forced 0 in the redirect cycle.
- DRAIN: each imem_rvalid decrements drop_cnt and is discarded. At drop_cnt reaching 0, state ← RUN and requests resume next cycle. A redirect during DRAIN adds the new outstanding to drop_cnt.
- Redirect together with en_n=1: flush still occurs; decode register clear is the hazard unit's responsibility.
- Output mux is combinational from buffer head; PC_plus4 = PC + 4 modulo 2^32.
- Assertions: rvalid with outstanding==0 && drop_cnt==0 is an error; buffer never overflows.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined:
  - redirect with redirect_pc[1:0]≠0 sets sticky misalign_err, and the unit halts requests until the next aligned redirect.
  - The aligned redirect clears misalign_err.
- Undefined:
  - misalign_err tied 0, redirect_pc[1:0] ignored (forced 2'b00).

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR = 32'h0000_0013
  - typedef enum {RUN, DRAIN} fetch_state_t
  - typedef struct packed {logic [31:0] instr; logic [31:0] pc;} fetch_entry_t
- Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full, empty.

Test Plan:
- Reset release, imem_gnt=1, 1-cycle rvalid latency, en_n=0 → addresses 0,4,8… issued; instr_valid by cycle 3; PC=0, PC_plus4=4.
- en_n=1 for 5 cycles with buffer full → imem_req=0 once buffered+outstanding=2; Instr/PC held; release pops in order with no loss or duplicate.
- Redirect to 32'h0000_0100 with 2 outstanding → next 2 rvalids discarded; DRAIN→RUN; next valid PC=0x100.
- Redirect during DRAIN with 1 more grant → drop_cnt accumulates; no stale instruction appears.
- fetch_pc at 32'hFFFF_FFFC granted → next imem_addr=0; PC_plus4 of that entry = 0.
- With FETCH_MISALIGN_CHECK_EN, redirect_pc=32'h102 → misalign_err=1, imem_req=0; then redirect to 0x200 → err cleared, fetch resumes at 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {RUN, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {instr, pc} entries; the head is read
// combinationally so decode sees it in the same cycle it becomes valid.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full buffer is accepted only when the head leaves this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    (push_i && !flush_i) |-> (!full_o || pop_i));

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the fetch PC, talks req/gnt/rvalid to imem and buffers results.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          BUF_DEPTH       = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        instr_valid,
  output logic        misalign_err
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [PW-1:0] addr_wr_q, addr_rd_q;
  logic          active_q;
  logic [31:0]   addr_mem [MAX_OUTSTANDING];

  logic          grant, resp, pop, halted;
  logic [31:0]   redir_pc;
  fetch_entry_t  head, push_entry;
  logic [CW-1:0] buf_count;
  logic          buf_full, buf_empty;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (redirect) err_q <= |redirect_pc[1:0];
  end

  assign redir_pc     = redirect_pc;
  assign halted       = err_q;
  assign misalign_err = err_q;
`else
  logic unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign redir_pc       = {redirect_pc[31:2], 2'b00};
  assign halted         = 1'b0;
  assign misalign_err   = 1'b0;
`endif

  // active_q keeps imem_req low until the first edge after reset release.
  assign imem_req = active_q && (state_q == RUN) && !halted && !redirect
                 && (int'(buf_count) + int'(outst_q) < BUF_DEPTH)
                 && (int'(outst_q) < MAX_OUTSTANDING);
  assign imem_addr = fetch_pc_q;

  assign grant = imem_req && imem_gnt;
  assign resp  = imem_rvalid && !redirect && (state_q == RUN) && (outst_q != '0);
  assign pop   = instr_valid && !en_n;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redirect) begin
      // Whatever is still owed by imem, minus a response landing right now, must be dropped.
      fetch_pc_d = redir_pc;
      outst_d    = '0;
      drop_d     = drop_q + outst_q + OW'(grant)
                 - OW'(imem_rvalid && ((outst_q != '0) || (drop_q != '0)));
      state_d    = (drop_d != '0) ? DRAIN : RUN;
    end else begin
      if (grant) fetch_pc_d = pc_inc(fetch_pc_q);
      if (state_q == RUN) begin
        outst_d = outst_q + OW'(grant) - OW'(resp);
      end else if (imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
        if (drop_d == '0) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      addr_wr_q  <= '0;
      addr_rd_q  <= '0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      active_q   <= 1'b1;
      if (redirect) begin
        addr_wr_q <= '0;
        addr_rd_q <= '0;
      end else begin
        if (grant) addr_wr_q <= (addr_wr_q == PTR_LAST) ? '0 : addr_wr_q + 1'b1;
        if (resp)  addr_rd_q <= (addr_rd_q == PTR_LAST) ? '0 : addr_rd_q + 1'b1;
      end
    end
  end

  // Request addresses are remembered at grant so responses can be tagged in order.
  always_ff @(posedge clk) begin
    if (grant) addr_mem[addr_wr_q] <= fetch_pc_q;
  end

  assign push_entry = '{instr: imem_rdata, pc: addr_mem[addr_rd_q]};

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect),
    .push_i      (resp),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (buf_count),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  assign instr_valid = !buf_empty;
  assign Instr       = instr_valid ? head.instr : NOP_INSTR;
  assign PC          = instr_valid ? head.pc : 32'h0;
  assign PC_plus4    = pc_inc(PC);

  assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> ((outst_q != '0) || (drop_q != '0)));

  assert property (@(posedge clk) disable iff (!rst_n)
    resp |-> (!buf_full || pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: imem responder plus a transaction-level model
// (queue of in-flight requests and of buffered PCs) checked every cycle.
module tb_fetch_unit;

  localparam int BUF_DEPTH = 2;
  localparam int MAX_OUT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instr, PC, PC_plus4;
  logic        instr_valid, misalign_err;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC        (32'h0000_0000),
    .BUF_DEPTH       (BUF_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_n         (en_n),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .Instr        (Instr),
    .PC           (PC),
    .PC_plus4     (PC_plus4),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } flight_t;

  int          checks = 0;
  int          failures = 0;
  flight_t     inflight[$];
  logic [31:0] exp_buf[$];
  logic [31:0] next_addr = 32'h0;
  bit          halted = 1'b0;
  logic [31:0] grant_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_p4_log[$];
  int          gnt_pct, rv_pct, stall_pct;
  int          step_no = 0;
  int          first_valid_step = -1;
  logic        last_req, last_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check state at negedge, drive inputs, check request, advance model.
  task automatic step(input bit do_redir, input logic [31:0] tgt);
    bit      exp_req, grant, popx;
    int      stale_n;
    flight_t r;
    @(negedge clk);
    step_no++;
    check("instr_valid", instr_valid, exp_buf.size() > 0);
    if (exp_buf.size() > 0) begin
      check("pc", PC, exp_buf[0]);
      check("instr", Instr, mem_word(exp_buf[0]));
      check("pc_plus4", PC_plus4, exp_buf[0] + 32'd4);
    end else begin
      check("nop_instr", Instr, 32'h0000_0013);
      check("idle_pc", PC, 32'h0);
      check("idle_pc_plus4", PC_plus4, 32'h4);
    end
    check("misalign_err", misalign_err, halted);
    if (instr_valid && first_valid_step < 0) first_valid_step = step_no;

    en_n        = ($urandom_range(0, 99) < stall_pct);
    redirect    = do_redir;
    redirect_pc = tgt;
    imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
    imem_rvalid = (inflight.size() > 0) && ($urandom_range(0, 99) < rv_pct);
    imem_rdata  = imem_rvalid ? mem_word(inflight[0].addr) : $urandom;
    #1;

    stale_n = 0;
    foreach (inflight[i]) if (inflight[i].stale) stale_n++;
    exp_req = !halted && (stale_n == 0) && !redirect
           && (exp_buf.size() + inflight.size() < BUF_DEPTH)
           && (inflight.size() < MAX_OUT);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, next_addr);
    last_req   = imem_req;
    last_valid = instr_valid;

    grant = exp_req && imem_gnt;
    popx  = (exp_buf.size() > 0) && !en_n && !redirect;
    if (popx) begin
      $display("pop pc=%h instr=%h", exp_buf[0], mem_word(exp_buf[0]));
      pop_pc_log.push_back(exp_buf[0]);
      pop_p4_log.push_back(PC_plus4);
      void'(exp_buf.pop_front());
    end
    if (imem_rvalid) begin
      r = inflight.pop_front();
      if (!r.stale && !redirect) exp_buf.push_back(r.addr);
    end
    if (redirect) begin
      exp_buf.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      next_addr = tgt;
      halted    = (tgt[1:0] != 2'b00);
`else
      next_addr = {tgt[31:2], 2'b00};
`endif
    end else if (grant) begin
      inflight.push_back('{addr: next_addr, stale: 1'b0});
      grant_log.push_back(next_addr);
      next_addr = next_addr + 32'd4;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic expect_pop(input string name, input int idx, input logic [31:0] pc);
    check({name, "_present"}, pop_pc_log.size() > idx, 1'b1);
    if (pop_pc_log.size() > idx) check(name, pop_pc_log[idx], pc);
  endtask

  initial begin
    int base, gbase;
    logic [31:0] tgt;

    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", Instr, 32'h0000_0013);
    check("rst_pc", PC, 32'h0);
    check("rst_pc_plus4", PC_plus4, 32'h4);
    check("rst_misalign", misalign_err, 1'b0);
    rst_n = 1'b1;
    #1;
    check("release_req", imem_req, 1'b0);

    // Streaming with always-grant and 1-cycle latency.
    gnt_pct = 100; rv_pct = 100; stall_pct = 0;
    run(10);
    check("first_valid_step", first_valid_step, 3);
    check("grant0", grant_log.size() > 2 ? grant_log[0] : 32'hDEAD, 32'h0);
    check("grant1", grant_log.size() > 2 ? grant_log[1] : 32'hDEAD, 32'h4);
    check("grant2", grant_log.size() > 2 ? grant_log[2] : 32'hDEAD, 32'h8);
    expect_pop("pop0", 0, 32'h0);
    check("pop0_plus4", pop_p4_log.size() > 0 ? pop_p4_log[0] : 32'hDEAD, 32'h4);

    // Decode stall fills the buffer and throttles requests.
    stall_pct = 100;
    run(5);
    check("stall_req", last_req, 1'b0);
    check("stall_valid", last_valid, 1'b1);
    stall_pct = 0;
    run(4);

    // Redirect with two requests outstanding.
    rv_pct = 0;
    run(5);
    check("model_outstanding", inflight.size(), 2);
    step(1'b1, 32'h0000_0100);
    base = pop_pc_log.size();
    rv_pct = 100;
    run(10);
    expect_pop("redir_first", base, 32'h0000_0100);

    // Second redirect while still draining.
    rv_pct = 0;
    run(5);
    step(1'b1, 32'h0000_0300);
    step(1'b1, 32'h0000_0400);
    base = pop_pc_log.size();
    rv_pct = 100;
    run(10);
    expect_pop("drain_redir_first", base, 32'h0000_0400);

    // Address wrap at the top of the 32-bit space.
    run(3);
    step(1'b1, 32'hFFFF_FFF8);
    base  = pop_pc_log.size();
    gbase = grant_log.size();
    run(10);
    expect_pop("wrap_a", base, 32'hFFFF_FFF8);
    expect_pop("wrap_b", base + 1, 32'hFFFF_FFFC);
    expect_pop("wrap_c", base + 2, 32'h0);
    check("wrap_plus4", pop_p4_log.size() > base + 1 ? pop_p4_log[base + 1] : 32'hDEAD, 32'h0);
    check("wrap_grant", grant_log.size() > gbase + 2 ? grant_log[gbase + 2] : 32'hDEAD, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    step(1'b1, 32'h0000_0102);
    run(4);
    check("misalign_set", misalign_err, 1'b1);
    check("misalign_req", last_req, 1'b0);
    step(1'b1, 32'h0000_0200);
    base = pop_pc_log.size();
    run(8);
    check("misalign_clear", misalign_err, 1'b0);
    expect_pop("misalign_resume", base, 32'h0000_0200);
`endif

    // Randomised traffic with stalls, slow memory and redirects.
    gnt_pct = 70; rv_pct = 60; stall_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                          : ($urandom & 32'h000F_FFFC);
        if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(0, 3));
        step(1'b1, tgt);
      end else begin
        step(1'b0, 32'h0);
      end
    end
    step(1'b1, 32'h0000_1000);
    rv_pct = 100; stall_pct = 0;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
